// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl
//   Four-digit code-lock controller. Keypad nibbles are accepted one at a
//   time; each latched digit is presented on cmp_a next to the key nibble for
//   the current position on cmp_b, and the external comparator's cmp_eq is
//   sampled one cycle later. A sticky mismatch flag collects per-digit results
//   so that only the whole-code outcome is visible: open the lock, or count a
//   failure and, after MAX_TRIES consecutive failures, enter a timed lockout.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   digit_valid  in   keypad digit present on digit
//   digit[3:0]   in   keypad nibble
//   clear        in   abort entry / relock early while open
//   digit_ready  out  a digit can be accepted this cycle
//   cmp_a[3:0]   out  latched entered digit, to comparator
//   cmp_b[3:0]   out  key nibble for current position, to comparator
//   cmp_eq       in   comparator equality result (combinational)
//   unlocked     out  lock is open
//   locked_out   out  lockout active, input ignored
//   fail_pulse   out  one-cycle strobe for a rejected code
//   fail_count   out  consecutive failures so far
module code_lock_ctrl #(
  parameter logic [15:0] KEY            = 16'h2612,
  parameter int          MAX_TRIES      = 3,
  parameter int          OPEN_CYCLES    = 8,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clear,
  output logic       digit_ready,
  output logic [3:0] cmp_a,
  output logic [3:0] cmp_b,
  input  logic       cmp_eq,
  output logic       unlocked,
  output logic       locked_out,
  output logic       fail_pulse,
  output logic [2:0] fail_count
);

  localparam logic [2:0]  MAX_TRIES_L = 3'(MAX_TRIES);
  localparam logic [15:0] OPEN_L      = 16'(OPEN_CYCLES);
  localparam logic [15:0] LOCKOUT_L   = 16'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_pos, w_pos_nxt;
  logic        r_mism, w_mism_nxt;
  logic [2:0]  r_fail_cnt, w_fail_nxt;
  logic [15:0] r_timer, w_timer_nxt;
  logic [3:0]  r_cmp_a, w_cmp_a_nxt;
  logic        r_fail_pulse, w_fail_pulse_nxt;

  // Mismatch including the digit being checked this cycle; the sticky flag
  // alone would miss a wrong final digit.
  logic        w_mism_eff;
  logic [2:0]  w_fail_inc;

  assign w_mism_eff = r_mism | ~cmp_eq;
  assign w_fail_inc = r_fail_cnt + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ENTRY;
      r_pos        <= 2'd0;
      r_mism       <= 1'b0;
      r_fail_cnt   <= 3'd0;
      r_timer      <= 16'd0;
      r_cmp_a      <= 4'd0;
      r_fail_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos        <= w_pos_nxt;
      r_mism       <= w_mism_nxt;
      r_fail_cnt   <= w_fail_nxt;
      r_timer      <= w_timer_nxt;
      r_cmp_a      <= w_cmp_a_nxt;
      r_fail_pulse <= w_fail_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos;
    w_mism_nxt       = r_mism;
    w_fail_nxt       = r_fail_cnt;
    w_timer_nxt      = r_timer;
    w_cmp_a_nxt      = r_cmp_a;
    w_fail_pulse_nxt = 1'b0;

    case (r_state)
      ENTRY: begin
        // clear wins over a digit presented in the same cycle
        if (clear) begin
          w_pos_nxt  = 2'd0;
          w_mism_nxt = 1'b0;
        end else if (digit_valid) begin
          w_cmp_a_nxt = digit;
          w_state_nxt = CHECK;
        end
      end

      CHECK: begin
        w_state_nxt = ENTRY;
        if (clear) begin
          w_pos_nxt  = 2'd0;
          w_mism_nxt = 1'b0;
        end else if (r_pos != 2'd3) begin
          w_mism_nxt = w_mism_eff;
          w_pos_nxt  = r_pos + 2'd1;
        end else begin
          w_pos_nxt  = 2'd0;
          w_mism_nxt = 1'b0;
          if (!w_mism_eff) begin
            w_state_nxt = OPEN;
            w_fail_nxt  = 3'd0;
            w_timer_nxt = OPEN_L;
          end else if (w_fail_inc < MAX_TRIES_L) begin
            w_fail_nxt       = w_fail_inc;
            w_fail_pulse_nxt = 1'b1;
          end else begin
            w_state_nxt      = LOCKOUT;
            w_fail_nxt       = MAX_TRIES_L;
            w_timer_nxt      = LOCKOUT_L;
            w_fail_pulse_nxt = 1'b1;
          end
        end
      end

      OPEN: begin
        w_timer_nxt = r_timer - 16'd1;
        if (clear || r_timer == 16'd1) begin
          w_state_nxt = ENTRY;
        end
      end

      LOCKOUT: begin
        w_timer_nxt = r_timer - 16'd1;
        if (r_timer == 16'd1) begin
          w_state_nxt = ENTRY;
          w_fail_nxt  = 3'd0;
        end
      end

      default: w_state_nxt = ENTRY;
    endcase
  end

  always_comb begin
    case (r_pos)
      2'd0:    cmp_b = KEY[15:12];
      2'd1:    cmp_b = KEY[11:8];
      2'd2:    cmp_b = KEY[7:4];
      default: cmp_b = KEY[3:0];
    endcase
  end

  assign digit_ready = (r_state == ENTRY);
  assign unlocked    = (r_state == OPEN);
  assign locked_out  = (r_state == LOCKOUT);
  assign cmp_a       = r_cmp_a;
  assign fail_pulse  = r_fail_pulse;
  assign fail_count  = r_fail_cnt;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl. The parent's equality comparator is
// modelled by a continuous assignment from cmp_a/cmp_b to cmp_eq.
module tb_code_lock_ctrl;

  localparam logic [15:0] K = 16'h2612;

  logic       clk;
  logic       reset_n;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       digit_ready;
  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       cmp_eq;
  logic       unlocked;
  logic       locked_out;
  logic       fail_pulse;
  logic [2:0] fail_count;

  int total = 0;
  int bad   = 0;
  int n;
  int nz;
  int pairs;
  logic prev;

  code_lock_ctrl #(
    .KEY(16'h2612), .MAX_TRIES(3), .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .digit_valid(digit_valid), .digit(digit),
    .clear(clear), .digit_ready(digit_ready), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_eq(cmp_eq), .unlocked(unlocked), .locked_out(locked_out),
    .fail_pulse(fail_pulse), .fail_count(fail_count)
  );

  assign cmp_eq = (cmp_a == cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One digit: accept edge, then the CHECK edge.
  task automatic enter_digit(input logic [3:0] d);
    chk("ready_before_digit", {15'd0, digit_ready}, 16'd1);
    digit_valid = 1'b1;
    digit       = d;
    step();
    chk("busy_in_check", {15'd0, digit_ready}, 16'd0);
    chk("cmp_a_latched", {12'd0, cmp_a}, {12'd0, d});
    digit_valid = 1'b0;
    step();
  endtask

  task automatic enter_code(input logic [15:0] c);
    logic [3:0] kn;
    for (int i = 0; i < 4; i++) begin
      kn = K[15-4*i -: 4];
      chk("cmp_b_pos", {12'd0, cmp_b}, {12'd0, kn});
      enter_digit(c[15-4*i -: 4]);
    end
  endtask

  // Counts remaining unlocked cycles including the current one.
  task automatic count_open(output int cnt);
    cnt = 0;
    while (unlocked && cnt < 50) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    clear       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset values
    chk("rst_ready", {15'd0, digit_ready}, 16'd1);
    chk("rst_unlocked", {15'd0, unlocked}, 16'd0);
    chk("rst_locked_out", {15'd0, locked_out}, 16'd0);
    chk("rst_fail_pulse", {15'd0, fail_pulse}, 16'd0);
    chk("rst_fail_count", {13'd0, fail_count}, 16'd0);
    chk("rst_cmp_a", {12'd0, cmp_a}, 16'd0);
    chk("rst_cmp_b", {12'd0, cmp_b}, 16'd2);
    reset_n = 1'b1;
    step();

    // correct code
    enter_code(16'h2612);
    chk("ok_unlocked", {15'd0, unlocked}, 16'd1);
    chk("ok_no_pulse", {15'd0, fail_pulse}, 16'd0);
    count_open(n);
    chk("ok_open_len", n[15:0], 16'd8);
    chk("ok_ready_after", {15'd0, digit_ready}, 16'd1);

    // wrong code, then correct
    enter_code(16'h2613);
    chk("bad_unlocked", {15'd0, unlocked}, 16'd0);
    chk("bad_pulse", {15'd0, fail_pulse}, 16'd1);
    chk("bad_count", {13'd0, fail_count}, 16'd1);
    chk("bad_ready", {15'd0, digit_ready}, 16'd1);
    step();
    chk("bad_pulse_one_cycle", {15'd0, fail_pulse}, 16'd0);
    enter_code(16'h2612);
    chk("retry_unlocked", {15'd0, unlocked}, 16'd1);
    chk("retry_count", {13'd0, fail_count}, 16'd0);
    count_open(n);

    // lockout
    enter_code(16'h0000);
    chk("lo_count1", {13'd0, fail_count}, 16'd1);
    chk("lo_pulse1", {15'd0, fail_pulse}, 16'd1);
    enter_code(16'h0000);
    chk("lo_count2", {13'd0, fail_count}, 16'd2);
    enter_code(16'h0000);
    chk("lo_count3", {13'd0, fail_count}, 16'd3);
    chk("lo_pulse3", {15'd0, fail_pulse}, 16'd1);
    chk("lo_active", {15'd0, locked_out}, 16'd1);
    digit_valid = 1'b1;
    digit       = 4'd5;
    n = 0;
    while (locked_out && n < 50) begin
      n++;
      step();
    end
    digit_valid = 1'b0;
    chk("lo_len", n[15:0], 16'd16);
    chk("lo_ready_after", {15'd0, digit_ready}, 16'd1);
    chk("lo_count_cleared", {13'd0, fail_count}, 16'd0);
    chk("lo_digits_ignored", {12'd0, cmp_a}, 16'd0);
    chk("lo_pos_reset", {12'd0, cmp_b}, 16'd2);

    // entry abort: clear beats a same-cycle digit
    enter_digit(4'd2);
    enter_digit(4'd6);
    clear       = 1'b1;
    digit_valid = 1'b1;
    digit       = 4'd9;
    step();
    clear       = 1'b0;
    digit_valid = 1'b0;
    chk("ab_ready", {15'd0, digit_ready}, 16'd1);
    chk("ab_digit_dropped", {12'd0, cmp_a}, 16'd6);
    chk("ab_pos_cleared", {12'd0, cmp_b}, 16'd2);
    // clear while in CHECK discards the digit
    digit_valid = 1'b1;
    digit       = 4'd2;
    step();
    digit_valid = 1'b0;
    clear       = 1'b1;
    step();
    clear = 1'b0;
    chk("abchk_pos", {12'd0, cmp_b}, 16'd2);
    chk("abchk_no_pulse", {15'd0, fail_pulse}, 16'd0);
    chk("abchk_ready", {15'd0, digit_ready}, 16'd1);
    enter_code(16'h2612);
    chk("ab_unlocked", {15'd0, unlocked}, 16'd1);
    chk("ab_count", {13'd0, fail_count}, 16'd0);

    // early relock on open cycle 3
    step();
    step();
    chk("rl_open_c3", {15'd0, unlocked}, 16'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("rl_relocked", {15'd0, unlocked}, 16'd0);
    chk("rl_ready", {15'd0, digit_ready}, 16'd1);

    // continuous digit_valid: one accept every 2 cycles
    digit_valid = 1'b1;
    digit       = 4'd2;
    nz    = 0;
    pairs = 0;
    prev  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (!digit_ready) nz++;
      if (!digit_ready && prev) pairs++;
      prev = !digit_ready;
    end
    digit_valid = 1'b0;
    chk("hold_accepts", nz[15:0], 16'd4);
    chk("hold_back_to_back", pairs[15:0], 16'd0);
    chk("hold_fail_count", {13'd0, fail_count}, 16'd1);
    chk("hold_fail_pulse", {15'd0, fail_pulse}, 16'd1);

    // asynchronous reset mid-entry
    enter_digit(4'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_e_cmp_a", {12'd0, cmp_a}, 16'd0);
    chk("ar_e_cmp_b", {12'd0, cmp_b}, 16'd2);
    chk("ar_e_count", {13'd0, fail_count}, 16'd0);
    chk("ar_e_ready", {15'd0, digit_ready}, 16'd1);
    step();
    reset_n = 1'b1;
    enter_code(16'h2612);
    chk("ar_e_unlock", {15'd0, unlocked}, 16'd1);
    count_open(n);

    // asynchronous reset mid-lockout
    enter_code(16'h1111);
    enter_code(16'h1111);
    enter_code(16'h1111);
    chk("ar_l_active", {15'd0, locked_out}, 16'd1);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("ar_l_locked_out", {15'd0, locked_out}, 16'd0);
    chk("ar_l_count", {13'd0, fail_count}, 16'd0);
    chk("ar_l_ready", {15'd0, digit_ready}, 16'd1);
    chk("ar_l_pulse", {15'd0, fail_pulse}, 16'd0);
    chk("ar_l_cmp_a", {12'd0, cmp_a}, 16'd0);
    step();
    reset_n = 1'b1;
    enter_code(16'h2612);
    chk("ar_l_unlock", {15'd0, unlocked}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Sequential 4-digit code-lock controller that feeds operands to the 4-bit equality comparator and consumes its match output. It accepts keypad nibbles one at a time, presents each nibble alongside the matching stored-key nibble to the comparator, and records mismatches. After the fourth digit it either opens the lock or counts a failure; repeated failures trigger a timed lockout. In the parent, `cmp_a` and `cmp_b` drive the comparator's `a`/`b` inputs, and the comparator's `aeqb` drives `cmp_eq`.

## Interface
- `KEY`, 16'h2612: stored code; the first digit entered is compared with `KEY[15:12]`, the last with `KEY[3:0]`.
- `MAX_TRIES`, 3: consecutive failed codes that trigger lockout; range 1..7.
- `OPEN_CYCLES`, 8: cycles `unlocked` stays high; must be at least 1.
- `LOCKOUT_CYCLES`, 16: cycles `locked_out` stays high; must be at least 1; the counter is 16 bits wide.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge triggered.
- `reset_n`, in, 1: asynchronous active-low reset.
- `digit_valid`, in, 1: a keypad digit is present on `digit`.
- `digit`, in, 4: keypad nibble.
- `clear`, in, 1: abort the current entry, or relock early while open.
- `digit_ready`, out, 1: the block can accept a digit this cycle.
- `cmp_a`, out, 4: latched entered digit, to the comparator.
- `cmp_b`, out, 4: key nibble selected by the current digit position, to the comparator.
- `cmp_eq`, in, 1: equality result from the comparator; combinational from `cmp_a`/`cmp_b`.
- `unlocked`, out, 1: the lock is open.
- `locked_out`, out, 1: lockout is active and input is ignored.
- `fail_pulse`, out, 1: one-cycle strobe marking a rejected code.
- `fail_count`, out, 3: consecutive failures so far.

## Operation
- **States:** the block has four states:
  - ENTRY: waiting for a digit.
  - CHECK: sampling `cmp_eq` for the latched digit.
  - OPEN: lock is open.
  - LOCKOUT: input is ignored until the timer expires.
- **Internal registers:**
  - `pos`, 2 bits: digit position.
  - `mism`: sticky mismatch flag.
  - `fail_cnt`, 3 bits: consecutive failures.
  - `timer`, 16 bits: shared by OPEN and LOCKOUT.
- **Reset state:**
  - State is ENTRY; `pos`, `mism`, `fail_cnt`, `timer` and `cmp_a` are 0.
  - Outputs are `unlocked`=0, `locked_out`=0, `fail_pulse`=0, `fail_count`=0, `digit_ready`=1.
  - `cmp_b` = `KEY[15:12]`.
- **Output decoding:**
  - `digit_ready` = (state==ENTRY).
  - `unlocked` = (state==OPEN); `locked_out` = (state==LOCKOUT).
  - `cmp_b` is decoded from `pos`.
  - `fail_pulse` is a register.
- **ENTRY:**
  - `digit_valid`=1 with `clear`=0: latch `digit` into `cmp_a` and go to CHECK.
  - `clear`=1: set `pos`=0 and `mism`=0, then stay in ENTRY. `clear` has priority over `digit_valid`.
- **CHECK:**
  - Set `mism` |= ~`cmp_eq`.
  - If `pos`<3: increment `pos` and return to ENTRY.
  - If `pos`==3, evaluate the effective mismatch (`mism` | ~`cmp_eq`):
    - No mismatch: go to OPEN, set `fail_cnt`=0, load `timer`=`OPEN_CYCLES`.
    - Mismatch, `fail_cnt`+1 < `MAX_TRIES`: increment `fail_cnt`, assert `fail_pulse`, return to ENTRY.
    - Mismatch, `fail_cnt`+1 == `MAX_TRIES`: assert `fail_pulse`, load `timer`=`LOCKOUT_CYCLES`, go to LOCKOUT, set `fail_cnt`=`MAX_TRIES`.
  - In every CHECK exit with `pos`==3, clear `pos` and `mism`.
  - `clear` in CHECK: the sampled digit is discarded, `pos` and `mism` clear, and the state returns to ENTRY. No failure is counted.
- **OPEN:**
  - Decrement `timer`. When `timer`==1, go to ENTRY.
  - `clear`=1 goes to ENTRY immediately.
  - `digit_valid` is ignored.
- **LOCKOUT:**
  - Decrement `timer`; `digit_valid` and `clear` are ignored.
  - When `timer`==1, go to ENTRY and set `fail_cnt`=0.
- **Mismatch reporting:** individual digit mismatches are never reported. Only the whole-code outcome is visible.
- **Dropped digits:** `digit_valid` while `digit_ready`=0 is dropped. There is no buffering.
- **`fail_count`** equals `fail_cnt`.

## Timing
- **Digit acceptance:** a digit accepted at edge T reaches `cmp_a` after T. CHECK occupies cycle T+1, and `cmp_eq` is sampled at the end of T+1. The comparator path is combinational and must settle within one cycle.
- **Throughput:** at most one digit every 2 cycles.
- **Latency:** from acceptance of the 4th digit to `unlocked`=1 is 2 edges. `unlocked` is high for exactly `OPEN_CYCLES` cycles unless `clear` ends it early.
- **`fail_pulse`:** high for exactly the one cycle following the final CHECK. In the lockout case this coincides with the first `locked_out` cycle.
- **`locked_out`:** high for exactly `LOCKOUT_CYCLES` cycles; `digit_ready` rises in the following cycle.
- **Mid-operation reset:** `reset_n` low in any state immediately forces all reset values, without waiting for a clock edge.

## Test plan
- **Correct code:** after reset, enter 2,6,1,2 with `digit_valid` for one cycle each and gaps of at least 1 cycle. Expect `cmp_b` to step through 2,6,1,2. `unlocked`=1 for 8 cycles starting 2 edges after the last accept; `fail_pulse` stays 0.
- **Wrong code:** enter 2,6,1,3. Expect no unlock, `fail_pulse` for 1 cycle, `fail_count`=1, and the state back in ENTRY. Then enter 2,6,1,2: expect unlock and `fail_count`=0.
- **Lockout:** enter 0,0,0,0 three times. Expect `fail_count` 1,2,3 and `locked_out`=1 for 16 cycles, during which any digits are ignored. Afterwards expect `fail_count`=0 and `digit_ready`=1.
- **Entry abort:** enter 2,6, pulse `clear`, then enter 2,6,1,2. Expect unlock with no failure counted. Also: a digit presented in the same cycle as `clear` is not accepted.
- **Early relock and dropped digit:** in OPEN, pulse `clear` on cycle 3; expect `unlocked` low the next cycle. Separately, hold `digit_valid` high continuously with digit 2; expect exactly one accept per 2 cycles.
- **Mid-operation reset:** assert `reset_n`=0 asynchronously mid-LOCKOUT and mid-entry. Expect all outputs at their reset values without waiting for a clock edge, and a full code works afterwards.
